// File: rtl/des_key_schedule.sv
// des_key_schedule: sequential DES PC-1/PC-2 round-key generator with a valid/ready subkey port.
// Defining DES_KEY_PARITY_CHECK_EN rejects keys whose bytes do not all have odd parity.
module des_key_schedule (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        decrypt,
  input  logic [63:0] key,
  input  logic        subkey_ready,
  output logic [47:0] subkey,
  output logic        subkey_valid,
  output logic [3:0]  round,
  output logic        busy,
  output logic        done,
  output logic        parity_err
);
  typedef enum logic {IDLE, RUN} state_t;
  localparam int PC1 [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,60,52,44,36,
                              63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,29,21,13,5,28,20,12,4};
  localparam int PC2 [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                              41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
  // bit i set where encryption round i+1 rotates by two instead of one
  localparam logic [15:0] SHIFT2 = 16'h7EFC;

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    for (int i = 0; i < 56; i++) r[6'(55 - i)] = k[6'(64 - PC1[i])];
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    for (int j = 0; j < 48; j++) r[6'(47 - j)] = cd[6'(56 - PC2[j])];
    return r;
  endfunction

  function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  function automatic logic odd_bytes(input logic [63:0] k);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 8; i++) ok &= ^k[6'(8 * i) +: 8];
    return ok;
  endfunction

  state_t      r_state, w_next;
  logic [27:0] r_c, r_d;
  logic [3:0]  r_round;
  logic        r_dir, r_done, r_perr;
  logic [55:0] w_pc1;
  logic        w_par_ok, w_start, w_accept, w_last, w_two;

  assign w_pc1 = pc1(key);
`ifdef DES_KEY_PARITY_CHECK_EN
  assign w_par_ok = odd_bytes(key);
`else
  logic w_unused_par;
  assign w_unused_par = ^{key[56], key[48], key[40], key[32], key[24], key[16], key[8], key[0]};
  assign w_par_ok = 1'b1;
`endif

  assign w_start  = (r_state == IDLE) && start;
  assign w_accept = (r_state == RUN) && subkey_ready;
  assign w_last   = w_accept && (r_round == 4'd15);
  // decryption walks the shift table backwards from round 16
  assign w_two    = r_dir ? SHIFT2[4'd15 - r_round] : SHIFT2[r_round + 4'd1];

  always_comb begin
    w_next = (w_start && w_par_ok) ? RUN : w_last ? IDLE : r_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_c     <= '0;
      r_d     <= '0;
      r_round <= '0;
      r_dir   <= 1'b0;
      r_done  <= 1'b0;
      r_perr  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= w_last;
      if (w_start) r_perr <= !w_par_ok;
      if (w_start && w_par_ok) begin
        r_c     <= decrypt ? w_pc1[55:28] : rotl(w_pc1[55:28], 1'b0);
        r_d     <= decrypt ? w_pc1[27:0] : rotl(w_pc1[27:0], 1'b0);
        r_round <= '0;
        r_dir   <= decrypt;
      end else if (w_accept && !w_last) begin
        r_round <= r_round + 4'd1;
        r_c     <= r_dir ? rotr(r_c, w_two) : rotl(r_c, w_two);
        r_d     <= r_dir ? rotr(r_d, w_two) : rotl(r_d, w_two);
      end
    end
  end

  assign subkey       = pc2({r_c, r_d});
  assign subkey_valid = (r_state == RUN);
  assign busy         = (r_state == RUN);
  assign round        = r_round;
  assign done         = r_done;
  assign parity_err   = r_perr;
endmodule

// File: tb/tb_des_key_schedule.sv
// tb_des_key_schedule: directed and randomized checks of des_key_schedule against a
// cumulative-shift DES key schedule model and published known-answer subkeys.
module tb_des_key_schedule;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, decrypt = 1'b0, subkey_ready = 1'b0;
  logic [63:0] key = '0;
  logic [47:0] subkey;
  logic        subkey_valid, busy, done, parity_err;
  logic [3:0]  round;
  int          checks = 0, failures = 0;
  logic [47:0] mk [16];
  logic [47:0] got [16];

  localparam logic [63:0] KEY = 64'h133457799BBCDFF1;
  localparam int PC1 [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,60,52,44,36,
                              63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,29,21,13,5,28,20,12,4};
  localparam int PC2 [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                              41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
  localparam int SH [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  always #5 clk = ~clk;

  des_key_schedule dut (
    .clk(clk), .rst_n(rst_n), .start(start), .decrypt(decrypt), .key(key),
    .subkey_ready(subkey_ready), .subkey(subkey), .subkey_valid(subkey_valid),
    .round(round), .busy(busy), .done(done), .parity_err(parity_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic coin();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [63:0] fix_par(input logic [63:0] k);
    for (int i = 0; i < 8; i++) k[6'(8 * i)] = ~^k[6'(8 * i + 1) +: 7];
    return k;
  endfunction

  // Ki = PC2(C0,D0 each rotated left by the running total of the shift table)
  task automatic model(input logic [63:0] k);
    logic [27:0] c, d;
    logic [55:0] cc, dd, cd;
    int tot = 0;
    for (int i = 0; i < 28; i++) begin
      c[5'(27 - i)] = k[6'(64 - PC1[i])];
      d[5'(27 - i)] = k[6'(64 - PC1[28 + i])];
    end
    cc = {c, c};
    dd = {d, d};
    for (int r = 0; r < 16; r++) begin
      tot += SH[r];
      cd = {cc[6'(55 - tot) -: 28], dd[6'(55 - tot) -: 28]};
      for (int j = 0; j < 48; j++) mk[r][6'(47 - j)] = cd[6'(56 - PC2[j])];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: ready held high; 1: random ready; 2: random ready plus random start pulses
  task automatic do_run(input logic [63:0] k, input logic dec, input int mode, input int abort_at);
    int n = 0;
    int cyc = 1;
    logic [47:0] exp;
    model(k);
    key = k;
    decrypt = dec;
    start = 1'b1;
    tick();
    start = 1'b0;
    key = {$urandom(), $urandom()};
    decrypt = coin();
    check("start_valid", subkey_valid, 1);
    check("start_busy", busy, 1);
    check("start_parity_err", parity_err, 0);
    while (n < 16 && cyc < 400) begin
      if (n == abort_at) return;
      exp = dec ? mk[15 - n] : mk[n];
      check("run_round", round, n);
      check("run_subkey_stable", subkey, exp);
      check("run_valid", subkey_valid, 1);
      check("run_done_low", done, 0);
      subkey_ready = (mode == 0) ? 1'b1 : coin();
      if (mode == 2) start = coin();
      if (subkey_ready) got[n] = subkey;
      tick();
      cyc++;
      if (subkey_ready) n++;
    end
    start = 1'b0;
    subkey_ready = 1'b0;
    check("run_complete", n, 16);
    check("final_done", done, 1);
    check("final_valid", subkey_valid, 0);
    check("final_busy", busy, 0);
    if (mode == 0) check("done_latency", cyc, 17);
  endtask

  initial begin
    #12;
    check("reset_subkey", subkey, 0);
    check("reset_valid", subkey_valid, 0);
    check("reset_round", round, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_parity_err", parity_err, 0);
    rst_n = 1'b1;
    tick();

    do_run(KEY, 1'b0, 0, -1);
    check("kat_enc_k1", got[0], 48'h1B02EFFC7072);
    check("kat_enc_k2", got[1], 48'h79AED9DBC9E5);
    check("kat_enc_k16", got[15], 48'hCB3D8B0E17F5);
    tick();
    check("done_single_pulse", done, 0);

    do_run(KEY, 1'b1, 0, -1);
    check("kat_dec_first", got[0], 48'hCB3D8B0E17F5);
    check("kat_dec_last", got[15], 48'h1B02EFFC7072);
    tick();

    do_run(KEY, 1'b0, 2, -1);
    check("kat_bp_k1", got[0], 48'h1B02EFFC7072);
    check("kat_bp_k16", got[15], 48'hCB3D8B0E17F5);
    tick();
    check("late_start_ignored_valid", subkey_valid, 0);
    check("late_start_ignored_done", done, 0);

    for (int i = 0; i < 6; i++) begin
      do_run(fix_par({$urandom(), $urandom()}), coin(), 1, -1);
      tick();
    end

    do_run(KEY, 1'b0, 0, 7);
    subkey_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_subkey", subkey, 0);
    check("async_reset_valid", subkey_valid, 0);
    check("async_reset_round", round, 0);
    check("async_reset_busy", busy, 0);
    check("async_reset_done", done, 0);
    #2 rst_n = 1'b1;
    tick();
    check("post_reset_no_done", done, 0);
    check("post_reset_idle", subkey_valid, 0);
    do_run(KEY, 1'b0, 0, -1);
    check("post_reset_k1", got[0], 48'h1B02EFFC7072);
    tick();

`ifdef DES_KEY_PARITY_CHECK_EN
    key = 64'h123457799BBCDFF1;
    decrypt = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("bad_parity_err", parity_err, 1);
    check("bad_parity_busy", busy, 0);
    check("bad_parity_valid", subkey_valid, 0);
    tick();
    check("bad_parity_sticky", parity_err, 1);
    check("bad_parity_no_done", done, 0);
    check("bad_parity_still_idle", subkey_valid, 0);
    do_run(KEY, 1'b0, 0, -1);
    check("good_parity_k1", got[0], 48'h1B02EFFC7072);
`else
    do_run(64'h123457799BBCDFF1, 1'b0, 1, -1);
    check("parity_ignored_k1", got[0], 48'h1B02EFFC7072);
    check("parity_ignored_err", parity_err, 0);
`endif
    tick();

    do_run(KEY, 1'b0, 0, -1);
    do_run(KEY, 1'b1, 0, -1);
    check("b2b_dec_first", got[0], 48'hCB3D8B0E17F5);
    check("b2b_dec_last", got[15], 48'h1B02EFFC7072);
    tick();
    check("b2b_done_cleared", done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
